// File: rtl/adder_prefix_seq_pkg.sv
// Shared definitions for the iterative parallel-prefix adder sequencer.
// Optional subtract support is selected with the ADDER_SEQ_SUB_EN macro.
package adder_prefix_seq_pkg;

    localparam int unsigned LEN_DATA = 32;
    localparam int unsigned STAGES   = $clog2(LEN_DATA);
    localparam int unsigned CNT_W    = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [LEN_DATA-1:0] sum;
        logic                cout;
        logic                ovf;
    } result_t;

    // Standard gp cell: returns {g, p} of the combined span (hi covers lo).
    function automatic logic [1:0] gp_combine(
        input logic g_hi,
        input logic p_hi,
        input logic g_lo,
        input logic p_lo
    );
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

endpackage

// File: rtl/adder_prefix_seq_prefix_level.sv
// One generate/propagate combining level of the prefix tree; the level
// index selects a span of 1 << level. Bits below the span pass through.
module prefix_level
    import adder_prefix_seq_pkg::*;
(
    input  logic [LEN_DATA-1:0] g,
    input  logic [LEN_DATA-1:0] p,
    input  logic [CNT_W-1:0]    level,
    output logic [LEN_DATA-1:0] g_next,
    output logic [LEN_DATA-1:0] p_next
);

    logic [STAGES-1:0][LEN_DATA-1:0] cand_g;
    logic [STAGES-1:0][LEN_DATA-1:0] cand_p;

    // Every candidate level is built in parallel; the level input picks one.
    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        localparam int SPAN = 1 << k;
        for (genvar i = 0; i < LEN_DATA; i++) begin : g_bit
            if (i >= SPAN) begin : g_comb
                assign {cand_g[k][i], cand_p[k][i]} =
                    gp_combine(g[i], p[i], g[i-SPAN], p[i-SPAN]);
            end else begin : g_pass
                assign cand_g[k][i] = g[i];
                assign cand_p[k][i] = p[i];
            end
        end
    end

    always_comb begin
        g_next = g;
        p_next = p;
        for (int k = 0; k < STAGES; k++) begin
            if (level == CNT_W'(k)) begin
                g_next = cand_g[k];
                p_next = cand_p[k];
            end
        end
    end

endmodule

// File: rtl/adder_prefix_seq.sv
// Iterative prefix adder: one combining level per clock, result held until
// the consumer takes it. Define ADDER_SEQ_SUB_EN to add the in_sub port.
module adder_prefix_seq
    import adder_prefix_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] in_a,
    input  logic [LEN_DATA-1:0] in_b,
    input  logic                in_cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic                in_sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf
);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [LEN_DATA-1:0] g_q;
    logic [LEN_DATA-1:0] p_q;
    logic [LEN_DATA-1:0] p_orig_q;
    logic                c0_q;
    result_t             res_q;
    logic                valid_q;

    logic                accept;
    logic                last_level;
    logic                release_res;
    logic [LEN_DATA-1:0] b_eff;
    logic                c0;
    logic [LEN_DATA-1:0] g_init;
    logic [LEN_DATA-1:0] p_init;
    logic [LEN_DATA-1:0] g_nx;
    logic [LEN_DATA-1:0] p_nx;
    logic [LEN_DATA-1:0] carry;
    result_t             res_nx;

    // Operand conditioning: subtract is a + ~b + 1.
`ifdef ADDER_SEQ_SUB_EN
    assign b_eff = in_b ^ {LEN_DATA{in_sub}};
    assign c0    = in_cin | in_sub;
`else
    assign b_eff = in_b;
    assign c0    = in_cin;
`endif

    always_comb begin
        p_init    = in_a ^ b_eff;
        g_init    = in_a & b_eff;
        g_init[0] = g_init[0] | (p_init[0] & c0);
    end

    prefix_level u_level (
        .g      (g_q),
        .p      (p_q),
        .level  (cnt_q),
        .g_next (g_nx),
        .p_next (p_nx)
    );

    // Final result from the last level's output, captured as DONE is entered.
    always_comb begin
        carry       = {g_nx[LEN_DATA-2:0], c0_q};
        res_nx.sum  = p_orig_q ^ carry;
        res_nx.cout = g_nx[LEN_DATA-1];
        res_nx.ovf  = carry[LEN_DATA-1] ^ g_nx[LEN_DATA-1];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_PREFIX;
            end
            ST_PREFIX: begin
                if (last_level) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = accept ? ST_PREFIX : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs derived from the current state.
    always_comb begin
        in_ready    = 1'b0;
        last_level  = 1'b0;
        release_res = 1'b0;
        case (state_q)
            ST_IDLE:   in_ready = 1'b1;
            ST_PREFIX: last_level = (cnt_q == CNT_W'(STAGES - 1));
            ST_DONE: begin
                in_ready    = out_ready;
                release_res = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
        accept = in_valid & in_ready;
    end

    // Prefix datapath: load on accept, one level per PREFIX cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            g_q      <= '0;
            p_q      <= '0;
            p_orig_q <= '0;
            c0_q     <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            g_q      <= g_init;
            p_q      <= p_init;
            p_orig_q <= p_init;
            c0_q     <= c0;
        end else if (state_q == ST_PREFIX) begin
            cnt_q <= cnt_q + CNT_W'(1);
            g_q   <= g_nx;
            p_q   <= p_nx;
        end
    end

    // Result registers change only when DONE is entered or left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else if (last_level) begin
            res_q   <= res_nx;
            valid_q <= 1'b1;
        end else if (release_res) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = res_q.sum;
    assign out_cout  = res_q.cout;
    assign out_ovf   = res_q.ovf;

endmodule

// File: doc/adder_prefix_seq.md
# adder_prefix_seq

Iterative sequencer for the parallel-prefix adder datapath: accepts one add/subtract operation through a valid/ready handshake and computes the carry tree over log2(LEN_DATA) clock cycles. Each cycle applies one generate/propagate combining level, doubling the span every cycle. It sits between the ALU issue logic and the writeback mux as a low-area alternative to the fully unrolled prefix adder. The result, carry-out and signed overflow are held until the consumer accepts them.

## Interface
- `LEN_DATA`, from `main.def.v` (32): operand width; must be a power of two and at least 2.
- `STAGES`, `$clog2(LEN_DATA)` (5): number of prefix levels, which is also the number of iteration cycles.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept an operation.
- `in_a`, `in_b`  in  LEN_DATA  operands.
- `in_cin`  in  1  carry-in.
- `in_sub`  in  1  subtract select (present only with `ADDER_SEQ_SUB_EN`).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  LEN_DATA  sum.
- `out_cout`  out  1  carry-out of the MSB.
- `out_ovf`  out  1  two's-complement overflow.

## Operation
- **States:** IDLE, PREFIX, DONE.
- **Reset:** state IDLE, stage counter 0, all registers 0. Reset values of outputs: `out_valid` 0, `out_sum` 0, `out_cout` 0, `out_ovf` 0, `in_ready` 1.
- **`in_ready`:** `in_ready` = (state==IDLE) | (state==DONE & `out_ready`).
- **Accept** (`in_valid` & `in_ready`):
  - b' = `in_b` ^ {LEN_DATA{sub}}.
  - Effective carry-in c0 = `in_cin` | sub.
  - Register p_orig = a ^ b'.
  - Initialise G = a & b' and P = p_orig, then G[0] |= P[0] & c0.
  - Latch c0 and the operand MSBs a[MSB], b'[MSB].
  - Go to PREFIX with counter = 0.
- **PREFIX, each cycle,** with span = 1 << counter:
  - For i ≥ span: G[i] ← G[i] | (P[i] & G[i−span]) and P[i] ← P[i] & P[i−span].
  - Bits with i < span are unchanged.
  - Counter increments by 1. When counter == STAGES−1 the level is still applied, then go to DONE.
- **DONE, carry vector:** c[0] = c0 and c[i] = G[i−1] for i ≥ 1.
- **DONE, outputs:**
  - `out_sum` = p_orig ^ c.
  - `out_cout` = G[LEN_DATA−1].
  - `out_ovf` = c[LEN_DATA−1] ^ `out_cout`.
  - `out_valid` = 1. The outputs are registered or derived only from registers, with no `in_*` path.
- **Leaving DONE:**
  - On `out_ready` with no new accept, go to IDLE.
  - On `out_ready` and a simultaneous accept, go straight to PREFIX with the new operands (back-to-back operation).
- **While `out_valid` & !`out_ready`:** all outputs stay stable and `in_ready` is 0.
- **Reset asserted mid-PREFIX or mid-DONE:** the operation is dropped and outputs return to their reset values immediately.
- **Width rules:**
  - Carry-out is not truncated into `out_sum`.
  - For subtraction, `out_cout` = 1 means no borrow.

## Timing
- **Latency:** operation accepted at edge E0 → `out_valid` = 1 after edge E0+STAGES (E0+5 at 32 bits).
- **Throughput:** one operation per STAGES+1 cycles when `out_ready` is held high. The DONE cycle overlaps with the next accept.
- **Idle gap:** `in_ready` is 0 for all PREFIX cycles.
- **Output stability:** `out_*` change only on edges where state enters or leaves DONE.

## Configuration
- **`ADDER_SEQ_SUB_EN` defined:**
  - The `in_sub` port exists.
  - Subtract is implemented as a + ~b + 1; `in_cin` is ignored when sub = 1.
- **`ADDER_SEQ_SUB_EN` undefined:**
  - The `in_sub` port is absent and sub is tied to 0.
  - The block is a pure adder with carry-in; the inversion logic is removed.

## Structure
- **Shared package / `main.def.v`:**
  - `LEN_DATA`.
  - State encodings IDLE=2'd0, PREFIX=2'd1, DONE=2'd2.
  - STAGES derivation.
- **Sub-module `prefix_level`:** combinational; inputs G, P and a span select, outputs next G and P.
  - It uses the same gp combine as the existing gp cells.
  - The sequencer instantiates it once and feeds back the registered G and P each cycle.

## Test plan
- 0xFFFFFFFF + 0x00000001, cin 0 → `out_sum` 0x00000000, `out_cout` 1, `out_ovf` 0, `out_valid` 5 cycles after accept.
- 0x7FFFFFFF + 0x00000001 → `out_sum` 0x80000000, `out_cout` 0, `out_ovf` 1.
- Sub (with `ADDER_SEQ_SUB_EN`) 5 − 7 → `out_sum` 0xFFFFFFFE, `out_cout` 0, `out_ovf` 0. Sub 7 − 5 → 0x00000002, `out_cout` 1.
- `out_ready` held low 10 cycles in DONE → `out_sum` stable, `in_ready` 0. Raising `out_ready` together with `in_valid` → new operation accepted that edge, its result appears 5 cycles later.
- `rst_n` pulsed low during PREFIX cycle 3 → `out_valid` never rises for that operation, `in_ready` = 1 after reset, the next operation 0x1 + 0x1 gives 0x2.
- Random 10k operands with random handshake stalls → every result matches the reference a + b + cin model; no result is lost or duplicated.
